// File: rtl/aes_sbox_arb.sv
// Arbitrates one shared S-box port between the AES-256 key expander and the round
// datapath, replaying latched key-load requests only while the S-box is free.
module aes_sbox_arb #(
  parameter int KEY_W  = 256,
  parameter int SBOX_W = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [KEY_W-1:0]  i_key,
  input  logic              i_key_en,
  output logic [KEY_W-1:0]  o_key,
  output logic              o_key_en,
  input  logic              i_ke_sbox_use,
  input  logic [SBOX_W-1:0] i_ke_sbox_din,
  output logic [SBOX_W-1:0] o_ke_sbox_dout,
  input  logic              i_ke_key_ok,
  output logic              o_key_ready,
  input  logic              i_dp_req,
  output logic              o_dp_gnt,
  input  logic              i_dp_done,
  input  logic [SBOX_W-1:0] i_dp_sbox_din,
  output logic [SBOX_W-1:0] o_dp_sbox_dout,
  output logic [SBOX_W-1:0] o_sbox_din,
  input  logic [SBOX_W-1:0] i_sbox_dout,
  output logic              o_conflict
);

  typedef enum logic [1:0] {IDLE, KEY, DATA} state_t;
  typedef enum logic {OWN_KEY, OWN_DATA} owner_t;

  state_t           state;
  state_t           next_state;
  owner_t           last_served;
  logic [KEY_W-1:0] r_key;
  logic             r_pend;
  logic             key_cand;
  logic             serve_key;
  logic             serve_data;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  // When both sides want the S-box, ownership alternates away from last_served.
  always_comb begin
    next_state = state;
    serve_key  = 1'b0;
    serve_data = 1'b0;
    key_cand   = r_pend | i_key_en;
    case (state)
      IDLE: begin
        if (key_cand && (!i_dp_req || last_served == OWN_DATA)) begin
          serve_key  = 1'b1;
          next_state = KEY;
        end else if (i_dp_req) begin
          serve_data = 1'b1;
          next_state = DATA;
        end
      end
      KEY:  if (!o_key_en && !i_ke_sbox_use) next_state = IDLE;
      DATA: if (i_dp_done || !i_dp_req)      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_key       <= '0;
      r_pend      <= 1'b0;
      o_key       <= '0;
      o_key_en    <= 1'b0;
      o_dp_gnt    <= 1'b0;
      o_conflict  <= 1'b0;
      last_served <= OWN_KEY;
    end else begin
      if (i_key_en) r_key <= i_key;
      // A request arriving in the serving cycle is consumed, not left pending.
      if (serve_key) begin
        o_key  <= i_key_en ? i_key : r_key;
        r_pend <= 1'b0;
      end else if (i_key_en) begin
        r_pend <= 1'b1;
      end
      o_key_en <= serve_key;
      o_dp_gnt <= (next_state == DATA);
      if (state == KEY  && next_state == IDLE) last_served <= OWN_KEY;
      if (state == DATA && next_state == IDLE) last_served <= OWN_DATA;
      if (i_ke_sbox_use && state != KEY) o_conflict <= 1'b1;
    end
  end

  always_comb begin
    o_sbox_din     = '0;
    o_ke_sbox_dout = '0;
    o_dp_sbox_dout = '0;
    case (state)
      KEY: begin
        o_sbox_din     = i_ke_sbox_din;
        o_ke_sbox_dout = i_sbox_dout;
      end
      DATA: begin
        o_sbox_din     = i_dp_sbox_din;
        o_dp_sbox_dout = i_sbox_dout;
      end
      default: ;
    endcase
    o_key_ready = i_ke_key_ok & ~r_pend & ~i_key_en & (state != KEY);
  end

endmodule

// File: tb/tb_aes_sbox_arb.sv
// Directed bench for aes_sbox_arb: table-driven S-box mux vectors plus hand-written
// sequences for key replay, arbitration, conflict and reset, against a simple expander model.
module tb_aes_sbox_arb;

  localparam int KEY_W  = 256;
  localparam int SBOX_W = 64;
  localparam logic [1:0] P_IDLE = 2'd0;
  localparam logic [1:0] P_KEY  = 2'd1;
  localparam logic [1:0] P_DATA = 2'd2;

  localparam logic [KEY_W-1:0] K1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [KEY_W-1:0] K2 = 256'h2222222222222222333333333333333344444444444444445555555555555555;
  localparam logic [KEY_W-1:0] K3 = 256'hc0dec0dec0dec0dec0dec0dec0dec0dec0dec0dec0dec0dec0dec0dec0de0000;
  localparam logic [KEY_W-1:0] KA = 256'haaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa;
  localparam logic [KEY_W-1:0] KB = 256'hbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbb;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [KEY_W-1:0]  key;
  logic              key_en;
  logic [KEY_W-1:0]  key_out;
  logic              key_en_out;
  logic              ke_sbox_use;
  logic [SBOX_W-1:0] ke_sbox_din;
  logic [SBOX_W-1:0] ke_sbox_dout;
  logic              ke_key_ok;
  logic              key_ready;
  logic              dp_req;
  logic              dp_gnt;
  logic              dp_done;
  logic [SBOX_W-1:0] dp_sbox_din;
  logic [SBOX_W-1:0] dp_sbox_dout;
  logic [SBOX_W-1:0] sbox_din;
  logic [SBOX_W-1:0] sbox_dout;
  logic              conflict;

  logic              force_use;
  int                busy_cnt;
  int                pass_count;
  int                check_count;

  always #5 clk = ~clk;

  aes_sbox_arb #(.KEY_W(KEY_W), .SBOX_W(SBOX_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_key(key), .i_key_en(key_en), .o_key(key_out), .o_key_en(key_en_out),
    .i_ke_sbox_use(ke_sbox_use), .i_ke_sbox_din(ke_sbox_din), .o_ke_sbox_dout(ke_sbox_dout),
    .i_ke_key_ok(ke_key_ok), .o_key_ready(key_ready),
    .i_dp_req(dp_req), .o_dp_gnt(dp_gnt), .i_dp_done(dp_done),
    .i_dp_sbox_din(dp_sbox_din), .o_dp_sbox_dout(dp_sbox_dout),
    .o_sbox_din(sbox_din), .i_sbox_dout(sbox_dout), .o_conflict(conflict)
  );

  // Expander stand-in: busy for 7 cycles after each init pulse, then raises key-ok.
  always @(posedge clk) begin
    if (!rst_n) begin
      busy_cnt  <= 0;
      ke_key_ok <= 1'b0;
    end else if (key_en_out) begin
      busy_cnt  <= 7;
      ke_key_ok <= 1'b0;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) ke_key_ok <= 1'b1;
    end
  end
  assign ke_sbox_use = (busy_cnt != 0) | force_use;

  typedef struct {
    logic [1:0]        phase;
    logic [SBOX_W-1:0] ke_din;
    logic [SBOX_W-1:0] dp_din;
    logic [SBOX_W-1:0] sb_dout;
    logic [SBOX_W-1:0] exp_din;
    logic [SBOX_W-1:0] exp_ke;
    logic [SBOX_W-1:0] exp_dp;
  } vec_t;

  vec_t tab[8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [KEY_W-1:0] actual,
                             input logic [KEY_W-1:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [SBOX_W-1:0] ke, input logic [SBOX_W-1:0] dp,
                               input logic [SBOX_W-1:0] sb);
    ke_sbox_din = ke;
    dp_sbox_din = dp;
    sbox_dout   = sb;
    #1;
  endtask

  task automatic enterPhase(input logic [1:0] p);
    if (p == P_KEY) begin
      key = K1;
      key_en = 1'b1;
      tick();
      key_en = 1'b0;
      checkOutput("table key pulse", key_en_out, 1'b1);
    end else if (p == P_DATA) begin
      dp_req = 1'b1;
      tick();
      checkOutput("table data grant latency", dp_gnt, 1'b1);
    end
  endtask

  task automatic leavePhase(input logic [1:0] p);
    int n;
    if (p == P_KEY) begin
      n = 0;
      while ((ke_sbox_use || key_en_out) && n < 30) begin
        tick();
        n++;
      end
      checkOutput("table key drain timeout", n < 30, 1'b1);
      tick();
    end else if (p == P_DATA) begin
      dp_req = 1'b0;
      tick();
    end
  endtask

  initial begin
    int n;
    int pulses;
    logic early;
    logic [1:0] cur;

    tab[0] = '{P_IDLE, 64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333, 64'h0, 64'h0, 64'h0};
    tab[1] = '{P_IDLE, 64'hffffffffffffffff, 64'hffffffffffffffff, 64'hffffffffffffffff, 64'h0, 64'h0, 64'h0};
    tab[2] = '{P_KEY,  64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0f0f0f0f0f0f0f0f, 64'h0123456789abcdef, 64'h0f0f0f0f0f0f0f0f, 64'h0};
    tab[3] = '{P_KEY,  64'h00000000deadbeef, 64'h5555555555555555, 64'h8000000000000001, 64'h00000000deadbeef, 64'h8000000000000001, 64'h0};
    tab[4] = '{P_KEY,  64'h0, 64'hffffffffffffffff, 64'h1234123412341234, 64'h0, 64'h1234123412341234, 64'h0};
    tab[5] = '{P_DATA, 64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0f0f0f0f0f0f0f0f, 64'hfedcba9876543210, 64'h0, 64'h0f0f0f0f0f0f0f0f};
    tab[6] = '{P_DATA, 64'hffffffffffffffff, 64'h0, 64'ha5a5a5a5a5a5a5a5, 64'h0, 64'h0, 64'ha5a5a5a5a5a5a5a5};
    tab[7] = '{P_DATA, 64'h1, 64'h2, 64'h3, 64'h2, 64'h0, 64'h3};

    pass_count = 0;
    check_count = 0;
    rst_n = 1'b0;
    key = '0;
    key_en = 1'b0;
    dp_req = 1'b0;
    dp_done = 1'b0;
    force_use = 1'b0;
    applyStimulus(64'h0, 64'h0, 64'h0);

    // Reset state
    tick();
    tick();
    rst_n = 1'b1;
    applyStimulus(64'h1111, 64'h2222, 64'h3333);
    checkOutput("reset key_en", key_en_out, 1'b0);
    checkOutput("reset dp_gnt", dp_gnt, 1'b0);
    checkOutput("reset conflict", conflict, 1'b0);
    checkOutput("reset key", key_out, '0);
    checkOutput("reset sbox_din", sbox_din, '0);
    checkOutput("reset key_ready", key_ready, 1'b0);

    // Key load from IDLE: pulse next cycle, ready 9 edges after the serve edge
    key = K1;
    key_en = 1'b1;
    tick();
    key_en = 1'b0;
    checkOutput("t1 key_en pulse", key_en_out, 1'b1);
    checkOutput("t1 key latched", key_out, K1);
    n = 0;
    while (!key_ready && n < 20) begin
      tick();
      n++;
      if (n == 1) checkOutput("t1 key_en one cycle", key_en_out, 1'b0);
    end
    checkOutput("t1 key_ready latency", n, 9);

    // Table-driven S-box mux vectors
    cur = P_IDLE;
    for (int i = 0; i < 8; i++) begin
      if (tab[i].phase != cur) begin
        leavePhase(cur);
        enterPhase(tab[i].phase);
        cur = tab[i].phase;
      end
      applyStimulus(tab[i].ke_din, tab[i].dp_din, tab[i].sb_dout);
      checkOutput($sformatf("vec%0d sbox_din", i), sbox_din, tab[i].exp_din);
      checkOutput($sformatf("vec%0d ke_dout", i), ke_sbox_dout, tab[i].exp_ke);
      checkOutput($sformatf("vec%0d dp_dout", i), dp_sbox_dout, tab[i].exp_dp);
    end
    leavePhase(cur);

    // Key request during a data block waits for release
    dp_req = 1'b1;
    tick();
    checkOutput("t2 grant", dp_gnt, 1'b1);
    key = K2;
    key_en = 1'b1;
    tick();
    key_en = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      if (key_en_out) pulses++;
      tick();
    end
    checkOutput("t2 no key_en during data", pulses, 0);
    checkOutput("t2 grant held", dp_gnt, 1'b1);
    dp_done = 1'b1;
    tick();
    dp_done = 1'b0;
    dp_req = 1'b0;
    checkOutput("t2 grant released", dp_gnt, 1'b0);
    tick();
    checkOutput("t2 key_en after release", key_en_out, 1'b1);
    checkOutput("t2 key replayed", key_out, K2);
    checkOutput("t2 no grant in key", dp_gnt, 1'b0);
    leavePhase(P_KEY);

    // Alternation: data block, then key and data requested together
    dp_req = 1'b1;
    tick();
    checkOutput("t3 first grant", dp_gnt, 1'b1);
    dp_done = 1'b1;
    tick();
    key = K3;
    key_en = 1'b1;
    for (int r = 0; r < 4; r++) begin
      tick();
      key_en = 1'b0;
      dp_done = 1'b0;
      checkOutput($sformatf("t3 r%0d key first", r), key_en_out, 1'b1);
      checkOutput($sformatf("t3 r%0d key value", r), key_out, K3 ^ KEY_W'(r));
      checkOutput($sformatf("t3 r%0d no grant", r), dp_gnt, 1'b0);
      n = 0;
      while (!dp_gnt && n < 30) begin
        tick();
        n++;
      end
      checkOutput($sformatf("t3 r%0d grant after key", r), n, 10);
      if (r < 3) begin
        key = K3 ^ KEY_W'(r + 1);
        key_en = 1'b1;
        tick();
        key_en = 1'b0;
      end
      dp_done = 1'b1;
      tick();
      dp_done = 1'b0;
      checkOutput($sformatf("t3 r%0d released", r), dp_gnt, 1'b0);
    end
    dp_req = 1'b0;
    tick();
    tick();

    // Two requests during KEY collapse into one replay of the newest key
    key = K1;
    key_en = 1'b1;
    tick();
    key_en = 1'b0;
    tick();
    key = KA;
    key_en = 1'b1;
    tick();
    key = KB;
    tick();
    key_en = 1'b0;
    checkOutput("t4 key unchanged mid-expansion", key_out, K1);
    pulses = 0;
    early = 1'b0;
    n = 0;
    while (!(key_ready && pulses != 0) && n < 40) begin
      if (key_en_out) begin
        pulses++;
        checkOutput("t4 replay key", key_out, KB);
      end
      if (key_ready && pulses == 0) early = 1'b1;
      tick();
      n++;
    end
    checkOutput("t4 single replay", pulses, 1);
    checkOutput("t4 ready not early", early, 1'b0);
    checkOutput("t4 ready reached", key_ready, 1'b1);

    // Conflict is sticky until reset
    applyStimulus(64'hcafecafecafecafe, 64'h0, 64'h0);
    force_use = 1'b1;
    tick();
    force_use = 1'b0;
    checkOutput("t5 conflict set", conflict, 1'b1);
    checkOutput("t5 sbox_din idle", sbox_din, '0);
    tick();
    tick();
    tick();
    checkOutput("t5 conflict sticky", conflict, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("t5 conflict cleared", conflict, 1'b0);

    // Reset in the middle of a key expansion drops the pending key too
    key = K2;
    key_en = 1'b1;
    tick();
    key_en = 1'b0;
    tick();
    key = KA;
    key_en = 1'b1;
    tick();
    key_en = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    checkOutput("t6 key_en", key_en_out, 1'b0);
    checkOutput("t6 key", key_out, '0);
    checkOutput("t6 dp_gnt", dp_gnt, 1'b0);
    checkOutput("t6 sbox_din", sbox_din, '0);
    checkOutput("t6 ke_dout", ke_sbox_dout, '0);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (key_en_out) pulses++;
    end
    checkOutput("t6 pending key lost", pulses, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
